// File: rtl/hazard_unit_pkg.sv
// Shared pipeline encodings for the hazard/bypass control: bypass selects,
// tnew/use timing codes, mult/div latencies and the tracked stage entry.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_GRF    = 2'd0,
        FWD_M      = 2'd1,
        FWD_E_LINK = 2'd2
    } fwd_sel_e;

    localparam logic [1:0] TNEW_LINK = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    localparam logic [1:0] USE_BRANCH = 2'd0;
    localparam logic [1:0] USE_ALU    = 2'd1;
    localparam logic [1:0] USE_STORE  = 2'd2;
    localparam logic [1:0] USE_NONE   = 2'd3;

    localparam logic [1:0] MD_NONE = 2'd0;
    localparam logic [1:0] MD_MULT = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;

    localparam logic [3:0] MDU_MULT_CYC = 4'd5;
    localparam logic [3:0] MDU_DIV_CYC  = 4'd10;

    typedef struct packed {
        logic [4:0] wreg;
        logic [1:0] tnew;
        logic       link;
    } stage_t;

    // Saturating tnew countdown as an entry ages by DEC stages.
    function automatic logic [1:0] tnew_dec(input logic [1:0] tnew, input logic [1:0] dec);
        return (tnew > dec) ? tnew - dec : 2'd0;
    endfunction

endpackage

// File: rtl/hazard_unit_stage.sv
// One tracked pipeline stage entry {wreg, tnew, link}; DEC sets how much
// tnew ages when the entry is captured (0 for E, 1 for M).
module hazard_stage_reg
    import hazard_unit_pkg::*;
#(
    parameter int unsigned DEC = 0
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   bubble_i,
    input  stage_t d_i,
    output stage_t q_o
);

    localparam logic [1:0] DEC_W = 2'(DEC);

    stage_t ent_q, ent_d;

    always_comb begin
        ent_d      = d_i;
        ent_d.tnew = tnew_dec(d_i.tnew, DEC_W);
        if (bubble_i) ent_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ent_q <= '0;
        else       ent_q <= ent_d;
    end

    assign q_o = ent_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: D-stage operand bypass selection, load-use/branch
// stalls against the E and M entries, and the mult/div busy interlock.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] rs_use,
    input  logic [1:0] rt_use,
    input  logic [4:0] wreg_d,
    input  logic [1:0] tnew_d,
    input  logic       link_d,
    input  logic [1:0] md_start_d,
    input  logic       md_use_d,
    output logic [1:0] trans_d1,
    output logic [1:0] trans_d2,
    output logic       stall_d,
    output logic       flush_e,
    output logic       md_busy
);

    stage_t e_q, m_q, ent_d;
    logic [3:0] cnt_q, cnt_d;
    logic data_stall, busy;

    assign ent_d = '{wreg: wreg_d, tnew: tnew_d, link: link_d};

    hazard_stage_reg #(.DEC(0)) u_stage_e (
        .clk(clk), .reset(reset), .bubble_i(stall_d), .d_i(ent_d), .q_o(e_q)
    );

    hazard_stage_reg #(.DEC(1)) u_stage_m (
        .clk(clk), .reset(reset), .bubble_i(1'b0), .d_i(e_q), .q_o(m_q)
    );

    function automatic logic hit(input logic [4:0] src, input stage_t s);
        return (src != 5'd0) && (src == s.wreg);
    endfunction

    function automatic logic needs_stall(input logic [4:0] src, input logic [1:0] use_c,
                                         input stage_t e, input stage_t m);
        if (use_c == USE_NONE) return 1'b0;
        return (hit(src, e) && (e.tnew > use_c)) || (hit(src, m) && (m.tnew > use_c));
    endfunction

    // A younger E match always shadows M, even when E cannot forward yet.
    function automatic fwd_sel_e pick(input logic [4:0] src, input stage_t e, input stage_t m);
        if (hit(src, e))
            return (e.link && e.tnew == TNEW_LINK) ? FWD_E_LINK : FWD_GRF;
        if (hit(src, m) && m.tnew == 2'd0)
            return FWD_M;
        return FWD_GRF;
    endfunction

    assign busy       = (cnt_q != 4'd0);
    assign data_stall = needs_stall(rs_d, rs_use, e_q, m_q) || needs_stall(rt_d, rt_use, e_q, m_q);
    assign stall_d    = !reset && (data_stall || (md_use_d && busy));
    assign flush_e    = stall_d;
    assign md_busy    = !reset && busy;
    assign trans_d1   = reset ? FWD_GRF : pick(rs_d, e_q, m_q);
    assign trans_d2   = reset ? FWD_GRF : pick(rt_d, e_q, m_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!stall_d && md_start_d == MD_MULT)      cnt_d = MDU_MULT_CYC;
        else if (!stall_d && md_start_d == MD_DIV)  cnt_d = MDU_DIV_CYC;
        else if (busy)                              cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= 4'd0;
        else       cnt_q <= cnt_d;
    end

endmodule
